// File: rtl/cursor_ctrl.sv
// Cursor controller: four raw buttons are synchronised, debounced and turned into
// single-step events on a saturating (x,y) cursor. Define CURSOR_AUTOREPEAT_EN for hold-to-repeat.
module cursor_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int GRID_MAX   = 7,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_RATE   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriba,
  input  logic       abajo,
  input  logic       izquierda,
  input  logic       derecha,
  output logic [3:0] x_select,
  output logic [3:0] y_select,
  output logic       move
);

  localparam int NBTN      = 4;
  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;

  localparam int              CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [3:0]      GMAX     = 4'(GRID_MAX);

  if (DEB_CYCLES < 2 || GRID_MAX < 1 || GRID_MAX > 15 || REP_DELAY < 1 || REP_RATE < 1) begin : g_param_err
    $error("cursor_ctrl: illegal parameter set");
  end

  logic [NBTN-1:0]  raw;
  logic [NBTN-1:0]  s1_q, s2_q;
  logic [NBTN-1:0]  deb_q, deb_d, deb_prev_q;
  logic [NBTN-1:0]  evt_q, evt_d;
  logic [NBTN-1:0]  rep_fire;
  logic [CNT_W-1:0] cnt_q [NBTN];
  logic [CNT_W-1:0] cnt_d [NBTN];
  logic [3:0]       x_q, x_d, y_q, y_d;
  logic             move_q, move_d;

  assign raw = {derecha, izquierda, abajo, arriba};

  // Debounce: the level only follows s2 once it has disagreed for DEB_CYCLES cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    deb_d = deb_q;
    for (int i = 0; i < NBTN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) deb_d[i] = s2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int HOLD_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] hold_q [NBTN];
  logic [HOLD_W-1:0] hold_d [NBTN];
  logic [NBTN-1:0]   rep_phase_q, rep_phase_d;

  // Hold counter targets REP_DELAY until the first repeat, then REP_RATE.
  always_comb begin
    rep_phase_d = rep_phase_q;
    rep_fire    = '0;
    for (int i = 0; i < NBTN; i++) begin
      hold_d[i] = '0;
      if (!deb_q[i]) begin
        rep_phase_d[i] = 1'b0;
      end else if (hold_q[i] == (rep_phase_q[i] ? HOLD_W'(REP_RATE) : HOLD_W'(REP_DELAY))) begin
        rep_fire[i]    = 1'b1;
        hold_d[i]      = HOLD_W'(1);
        rep_phase_d[i] = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_phase_q <= '0;
      for (int i = 0; i < NBTN; i++) hold_q[i] <= '0;
    end else begin
      rep_phase_q <= rep_phase_d;
      for (int i = 0; i < NBTN; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign rep_fire = '0;
`endif

  assign evt_d = (deb_q & ~deb_prev_q) | rep_fire;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      evt_q      <= '0;
      // NOTE: the counter array is reset too, so a press pending at reset is discarded.
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      s1_q       <= raw;
      s2_q       <= s1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      evt_q      <= evt_d;
      for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Opposite events on one axis cancel; each axis saturates at 0 and GRID_MAX.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (evt_q[BTN_DOWN] && !evt_q[BTN_UP]) begin
      if (y_q != GMAX) y_d = y_q + 4'd1;
    end else if (evt_q[BTN_UP] && !evt_q[BTN_DOWN]) begin
      if (y_q != 4'd0) y_d = y_q - 4'd1;
    end
    if (evt_q[BTN_RIGHT] && !evt_q[BTN_LEFT]) begin
      if (x_q != GMAX) x_d = x_q + 4'd1;
    end else if (evt_q[BTN_LEFT] && !evt_q[BTN_RIGHT]) begin
      if (x_q != 4'd0) x_d = x_q - 4'd1;
    end
    move_d = (x_d != x_q) || (y_d != y_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      move_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      move_q <= move_d;
    end
  end

  assign x_select = x_q;
  assign y_select = y_q;
  assign move     = move_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Self-checking bench for cursor_ctrl: directed sequences, a press table and random
// stimulus, all compared against a behavioural sliding-window model of the buttons.
module tb_cursor_ctrl;

  localparam int DEB = 4;
  localparam int GM  = 7;
  localparam int RD  = 20;
  localparam int RR  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       arriba = 1'b0, abajo = 1'b0, izquierda = 1'b0, derecha = 1'b0;
  logic [3:0] x_select, y_select;
  logic       move;

  int n_checks = 0;
  int n_fail   = 0;

  cursor_ctrl #(
    .DEB_CYCLES(DEB), .GRID_MAX(GM), .REP_DELAY(RD), .REP_RATE(RR)
  ) dut (
    .clk(clk), .rst(rst),
    .arriba(arriba), .abajo(abajo), .izquierda(izquierda), .derecha(derecha),
    .x_select(x_select), .y_select(y_select), .move(move)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_btn(input logic [3:0] m);
    arriba    = m[0];
    abajo     = m[1];
    izquierda = m[2];
    derecha   = m[3];
  endtask

  // Reference model. A button's debounced level flips at edge n when the raw samples
  // taken at edges n-DEB-1 .. n-2 all differ from it; events follow one edge later
  // and the cursor one edge after that.
  int          m_x, m_y, m_edge;
  logic        m_move;
  logic [3:0]  m_deb, m_rose, m_evt;
  logic [15:0] m_hist [4];
`ifdef CURSOR_AUTOREPEAT_EN
  logic [3:0]  m_pvalid;
  int          m_pedge [4];
`endif

  task automatic model_clear();
    m_x = 0; m_y = 0; m_move = 1'b0; m_edge = 0;
    m_deb = '0; m_rose = '0; m_evt = '0;
    for (int b = 0; b < 4; b++) m_hist[b] = '0;
`ifdef CURSOR_AUTOREPEAT_EN
    m_pvalid = '0;
    for (int b = 0; b < 4; b++) m_pedge[b] = 0;
`endif
  endtask

  task automatic model_step();
    logic [3:0] raw, nevt;
    bit         all_diff;
    int         nx, ny;
    raw = {derecha, izquierda, abajo, arriba};
    m_edge++;
    nx = m_x;
    ny = m_y;
    if (m_evt[3] && !m_evt[2])      nx = (m_x < GM) ? m_x + 1 : m_x;
    else if (m_evt[2] && !m_evt[3]) nx = (m_x > 0)  ? m_x - 1 : m_x;
    if (m_evt[1] && !m_evt[0])      ny = (m_y < GM) ? m_y + 1 : m_y;
    else if (m_evt[0] && !m_evt[1]) ny = (m_y > 0)  ? m_y - 1 : m_y;
    m_move = (nx != m_x) || (ny != m_y);
    m_x = nx;
    m_y = ny;
    for (int b = 0; b < 4; b++) begin
      nevt[b] = m_rose[b];
`ifdef CURSOR_AUTOREPEAT_EN
      if (!m_rose[b] && m_deb[b] && m_pvalid[b]) begin
        int d;
        d = m_edge - m_pedge[b];
        if (d == RD || (d > RD && (d - RD) % RR == 0)) nevt[b] = 1'b1;
      end
      if (m_rose[b]) begin
        m_pvalid[b] = 1'b1;
        m_pedge[b]  = m_edge;
      end
`endif
    end
    for (int b = 0; b < 4; b++) begin
      m_hist[b] = {m_hist[b][14:0], raw[b]};
      all_diff = 1'b1;
      for (int j = 2; j <= DEB + 1; j++)
        if (m_hist[b][j] == m_deb[b]) all_diff = 1'b0;
      m_rose[b] = 1'b0;
      if (all_diff) begin
        m_deb[b]  = ~m_deb[b];
        m_rose[b] = m_deb[b];
`ifdef CURSOR_AUTOREPEAT_EN
        if (!m_deb[b]) m_pvalid[b] = 1'b0;
`endif
      end
    end
    m_evt = nevt;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_clear();
      else      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_x", x_select, m_x);
      check("model_y", y_select, m_y);
      check("model_move", move, m_move);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic async_reset(input logic [3:0] hold_btn);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_x", x_select, 0);
    check("async_rst_y", y_select, 0);
    check("async_rst_move", move, 0);
    set_btn(hold_btn);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_count(input int n, output int moves);
    moves = 0;
    repeat (n) begin
      @(negedge clk);
      if (move === 1'b1) moves++;
    end
  endtask

  typedef struct {
    logic [3:0] btn;
    int         ex;
    int         ey;
    int         emv;
  } vec_t;

  vec_t tbl [19];

  initial begin
    int         mv;
    int         rem [4];
    logic [3:0] rv;

    // Press table from (0,0); each press is held 10 cycles then released 10 cycles.
    tbl[0] = '{4'b1010, 1, 1, 1};
    for (int i = 1; i <= 6; i++) tbl[i] = '{4'b1000, i + 1, 1, 1};
    for (int i = 7; i <= 9; i++) tbl[i] = '{4'b1000, 7, 1, 0};
    tbl[10] = '{4'b0001, 7, 0, 1};
    tbl[11] = '{4'b0001, 7, 0, 0};
    for (int i = 12; i <= 14; i++) tbl[i] = '{4'b0010, 7, i - 11, 1};
    tbl[15] = '{4'b0011, 7, 3, 0};
    tbl[16] = '{4'b0100, 6, 3, 1};
    tbl[17] = '{4'b1100, 6, 3, 0};
    tbl[18] = '{4'b0101, 5, 2, 1};

    set_btn(4'b0000);
    #1;
    check("reset_x", x_select, 0);
    check("reset_y", y_select, 0);
    check("reset_move", move, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Clean press: derecha first sampled at edge k, cursor moves at edge k+7.
    set_btn(4'b1000);
    repeat (7) @(negedge clk);
    check("press_pre_x", x_select, 0);
    check("press_pre_move", move, 0);
    @(negedge clk);
    check("press_x", x_select, 1);
    check("press_move", move, 1);
    @(negedge clk);
    check("press_move_drop", move, 0);
    repeat (41) @(negedge clk);
    set_btn(4'b0000);
    repeat (20) @(negedge clk);
`ifdef CURSOR_AUTOREPEAT_EN
    check("hold_x", x_select, 5);
`else
    check("hold_x", x_select, 1);
`endif
    check("hold_y", y_select, 0);

    // Glitch shorter than the debounce window.
    set_btn(4'b0010);
    repeat (3) @(negedge clk);
    set_btn(4'b0000);
    run_count(20, mv);
    check("glitch_moves", mv, 0);
    check("glitch_y", y_select, 0);

    // Reset mid-debounce discards the pending press.
    set_btn(4'b1000);
    repeat (4) @(negedge clk);
    async_reset(4'b0000);
    run_count(20, mv);
    check("middeb_moves", mv, 0);
    check("middeb_x", x_select, 0);

    // Button held across reset counts as a fresh press afterwards.
    set_btn(4'b1000);
    repeat (12) @(negedge clk);
    async_reset(4'b1000);
    repeat (7) @(negedge clk);
    check("held_rst_pre_x", x_select, 0);
    @(negedge clk);
    check("held_rst_x", x_select, 1);
    check("held_rst_move", move, 1);
    repeat (5) @(negedge clk);
    set_btn(4'b0000);
    repeat (12) @(negedge clk);
    async_reset(4'b0000);

    for (int i = 0; i < 19; i++) begin
      set_btn(tbl[i].btn);
      mv = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (move === 1'b1) mv++;
        if (c == 9) set_btn(4'b0000);
      end
      check($sformatf("tbl%0d_x", i), x_select, tbl[i].ex);
      check($sformatf("tbl%0d_y", i), y_select, tbl[i].ey);
      check($sformatf("tbl%0d_moves", i), mv, tbl[i].emv);
    end

`ifdef CURSOR_AUTOREPEAT_EN
    // Auto-repeat: y=1 at k+7, y=2 at k+27, then +1 every 8 cycles up to 7.
    async_reset(4'b0000);
    set_btn(4'b0010);
    mv = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (move === 1'b1) mv++;
      if (i == 7)  check("rep_pre_y", y_select, 0);
      if (i == 8)  check("rep_first_y", y_select, 1);
      if (i == 27) check("rep_wait_y", y_select, 1);
      if (i == 28) check("rep_second_y", y_select, 2);
      if (i == 36) check("rep_third_y", y_select, 3);
      if (i == 68) check("rep_sat_y", y_select, 7);
    end
    check("rep_moves", mv, 7);
    set_btn(4'b0000);
    repeat (20) @(negedge clk);
    check("rep_final_y", y_select, 7);

    async_reset(4'b0000);
    set_btn(4'b0010);
    repeat (30) @(negedge clk);
    check("midhold_pre_y", y_select, 2);
    async_reset(4'b0000);
    run_count(40, mv);
    check("midhold_moves", mv, 0);
    check("midhold_y", y_select, 0);
`endif

    // Random button activity; the model checker compares every cycle.
    rv = '0;
    for (int b = 0; b < 4; b++) rem[b] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == 200) async_reset(rv);
      for (int b = 0; b < 4; b++) begin
        if (rem[b] == 0) begin
          rv[b]  = 1'($urandom_range(0, 1));
          rem[b] = $urandom_range(1, 30);
        end else begin
          rem[b]--;
        end
      end
      set_btn(rv);
    end
    set_btn(4'b0000);
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
